regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Write-port controller for the 32x32 MIPS register file.
//  - Arbitrates between two write-back requesters: ALU and MEM (loads).
//  - Sequences byte/halfword writes as read-modify-write through the file's
//    combinational read port.
//  - Is the only block that drives the register file's regWrite strobe.
// PARAMETERS
//  DATA_W  32  register width in bits; must be 32 (4 byte lanes)
//  ADDR_W  5   register index width
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high reset
//  alu_valid      in   1       ALU write request
//  alu_ready      out  1       ALU request accepted this cycle
//  alu_reg        in   ADDR_W  ALU destination register
//  alu_data       in   DATA_W  ALU write data
//  alu_be         in   4       ALU byte-lane enables; 4'b1111 = full word
//  mem_valid      in   1       MEM write request
//  mem_ready      out  1       MEM request accepted this cycle
//  mem_reg        in   ADDR_W  MEM destination register
//  mem_data       in   DATA_W  MEM write data
//  mem_be         in   4       MEM byte-lane enables
//  rf_read_reg    out  ADDR_W  register file read index (RMW old value)
//  rf_read_data   in   DATA_W  register file read data (combinational)
//  rf_write_reg   out  ADDR_W  register file write index
//  rf_write_data  out  DATA_W  register file write data
//  rf_reg_write   out  1       register file write strobe; one-cycle pulse
//  busy           out  1       FSM is not in IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; rr pointer favours MEM.
//  - Reset is asynchronous: it clears everything, including mid-RMW.
//    The in-flight write is dropped, and rf_reg_write falls with reset.
//  - FSM states: IDLE, READ, WRITE.
//  - IDLE: if any valid, grant one requester.
//    - Only the granted requester's ready is high that cycle.
//    - Request fields are registered on that edge.
//    - Next state:
//      - reg==0 or be==0: request is accepted and discarded; stay IDLE.
//      - be==4'b1111: go to WRITE.
//      - otherwise: go to READ.
//  - READ: rf_read_reg = captured reg. Merged word is registered at the
//    end of the cycle; go to WRITE.
//  - WRITE: rf_reg_write=1, with rf_write_reg/rf_write_data stable; go to IDLE.
//  - Ready is never asserted outside IDLE. A requester holds valid and its
//    fields stable until it sees ready.
//  - Latency from accept edge to rf_reg_write cycle:
//    - full word: 1 cycle
//    - partial: 2 cycles
//  - Throughput: 1 write per 2 cycles (full word), 1 per 3 cycles (partial).
//  - Merge: lane i = new_data[8i+7:8i] if be[i], else rf_read_data lane i.
//  - Outside WRITE: rf_reg_write=0, rf_write_* hold their last values.
//  - Outside READ: rf_read_reg=0.
//  - busy = (state != IDLE).
// CONFIGURATION
//  REGW_ROUND_ROBIN_EN
//  - defined: round-robin arbitration.
//    - After a grant, the other requester wins the next simultaneous request.
//    - The 1-bit pointer updates only on a grant (including discarded
//      requests).
//  - undefined: fixed priority, MEM over ALU; no pointer state.
//  - Single-requester behaviour is identical either way.
// STRUCTURE
//  - Package regfile_pkg:
//    - state encoding IDLE=2'd0, READ=2'd1, WRITE=2'd2
//    - BE_FULL=4'b1111
//    - REQ_MEM=1'b0, REQ_ALU=1'b1
//  - Sub-module byte_lane_merge: combinational merge of
//    (new_data, old_data, be) -> merged.
// TESTING
//  - Full word: alu reg=5, data=32'hDEADBEEF, be=F.
//    -> alu_ready in cycle 0; rf_reg_write in cycle 1 with reg 5, 32'hDEADBEEF.
//  - Byte write: mem reg=9, data=32'h000000AB, be=0001, rf_read_data=32'h11223344.
//    -> READ cycle with rf_read_reg=9; next cycle writes 32'h112233AB.
//  - Contention: both valid, full words, held for 3 requests.
//    - fixed priority: all MEM first, ALU only after mem_valid drops.
//    - REGW_ROUND_ROBIN_EN: MEM, ALU, MEM grant order.
//  - Discards: alu reg=0, or be=0.
//    -> ready pulses, rf_reg_write stays 0, busy stays 0.
//  - Reset in READ: assert reset mid-RMW.
//    -> busy=0, rf_reg_write=0 immediately; no write after release.
//  - Back-to-back: hold alu_valid with full-word writes.
//    -> ready every 2nd cycle; no ready while busy.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port controller.
//   state_e  : controller FSM encoding (idle / read-for-merge / write strobe)
//   BE_FULL  : byte-enable pattern for a full-word write (skips the RMW read)
//   REQ_MEM / REQ_ALU : requester identifiers used by the arbiter pointer
package regfile_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } state_e;

  localparam logic [3:0] BE_FULL = 4'b1111;

  localparam logic REQ_MEM = 1'b0;
  localparam logic REQ_ALU = 1'b1;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge for read-modify-write of partial registers.
//   new_data_i : incoming write data
//   old_data_i : current register contents from the file's read port
//   be_i       : per-lane enables; a set bit takes the lane from new_data_i
//   merged_o   : merged word
module byte_lane_merge #(
  parameter int unsigned DataW = 32
) (
  input  logic [DataW-1:0]   new_data_i,
  input  logic [DataW-1:0]   old_data_i,
  input  logic [DataW/8-1:0] be_i,
  output logic [DataW-1:0]   merged_o
);

  always_comb begin
    merged_o = old_data_i;
    for (int i = 0; i < DataW / 8; i++) begin
      if (be_i[i]) begin
        merged_o[8*i +: 8] = new_data_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the 32x32 MIPS register file.
// Arbitrates ALU and MEM write-back requests, performs byte/halfword writes as
// read-modify-write through the file's combinational read port, and is the sole
// driver of the register file's write strobe.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   alu_valid/ready/reg/data/be ALU write-back request channel
//   mem_valid/ready/reg/data/be MEM (load) write-back request channel
//   rf_read_reg, rf_read_data   read port used to fetch the old value for RMW
//   rf_write_reg/data           write index/data; hold last value outside WRITE
//   rf_reg_write                one-cycle write strobe
//   busy                        controller is not idle
//
// Configuration:
//   REGW_ROUND_ROBIN_EN  defined   -> round-robin between simultaneous requests
//                        undefined -> fixed priority, MEM over ALU
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [3:0]        alu_be,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              pick_mem;
  logic              sel;
  logic              grant;
  logic [ADDR_W-1:0] req_reg;
  logic [DATA_W-1:0] req_data;
  logic [3:0]        req_be;
  logic [DATA_W-1:0] merged;

  // Arbitration: which requester wins if a grant is issued this cycle.
`ifdef REGW_ROUND_ROBIN_EN
  // rr_q names the requester favoured on the next simultaneous request.
  logic rr_q, rr_d;

  always_comb begin
    pick_mem = mem_valid & (~alu_valid | (rr_q == REQ_MEM));
    rr_d     = rr_q;
    if (grant) begin
      rr_d = (sel == REQ_MEM) ? REQ_ALU : REQ_MEM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= REQ_MEM;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  always_comb begin
    pick_mem = mem_valid;
  end
`endif

  always_comb begin
    sel      = pick_mem ? REQ_MEM : REQ_ALU;
    // Ready is gated by reset so every output reads 0 while reset is held.
    grant    = (state_q == StIdle) & (mem_valid | alu_valid) & ~reset;
    req_reg  = (sel == REQ_MEM) ? mem_reg  : alu_reg;
    req_data = (sel == REQ_MEM) ? mem_data : alu_data;
    req_be   = (sel == REQ_MEM) ? mem_be   : alu_be;
  end

  byte_lane_merge #(
    .DataW (DATA_W)
  ) u_merge (
    .new_data_i (data_q),
    .old_data_i (rf_read_data),
    .be_i       (be_q),
    .merged_o   (merged)
  );

  always_comb begin
    state_d     = state_q;
    reg_d       = reg_q;
    data_d      = data_q;
    be_d        = be_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    alu_ready   = 1'b0;
    mem_ready   = 1'b0;
    rf_read_reg = '0;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          alu_ready = (sel == REQ_ALU);
          mem_ready = (sel == REQ_MEM);
          reg_d     = req_reg;
          data_d    = req_data;
          be_d      = req_be;
          if (req_reg == '0 || req_be == 4'b0000) begin
            // $zero or empty-lane writes are accepted and dropped.
            state_d = StIdle;
          end else if (req_be == BE_FULL) begin
            state_d = StWrite;
            wreg_d  = req_reg;
            wdata_d = req_data;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        rf_read_reg = reg_q;
        wreg_d      = reg_q;
        wdata_d     = merged;
        state_d     = StWrite;
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      reg_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_write_reg  = wreg_q;
  assign rf_write_data = wdata_q;
  assign rf_reg_write  = (state_q == StWrite);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic [3:0]  alu_be;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_reg_write;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_reg       (alu_reg),
    .alu_data      (alu_data),
    .alu_be        (alu_be),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_reg       (mem_reg),
    .mem_data      (mem_data),
    .mem_be        (mem_be),
    .rf_read_reg   (rf_read_reg),
    .rf_read_data  (rf_read_data),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves time just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic exp_mem;

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0; alu_be = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0; mem_be = '0;
    rf_read_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr", rf_reg_write, 0);
    check("rst_wreg", rf_write_reg, 0);
    check("rst_wdata", rf_write_data, 0);
    check("rst_rreg", rf_read_reg, 0);
    alu_valid = 1'b1; alu_reg = 5'd1; alu_be = 4'hF;
    #1;
    check("rst_ready", alu_ready, 0);
    alu_valid = 1'b0;
    reset = 1'b0;
    step();

    // Full-word ALU write.
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF; alu_be = 4'hF;
    #1;
    check("fw_alu_ready", alu_ready, 1);
    check("fw_mem_ready", mem_ready, 0);
    step();
    check("fw_wr", rf_reg_write, 1);
    check("fw_wreg", rf_write_reg, 5);
    check("fw_wdata", rf_write_data, 32'hDEADBEEF);
    check("fw_busy", busy, 1);
    check("fw_no_ready_busy", alu_ready, 0);
    alu_valid = 1'b0;
    step();
    check("fw_idle_busy", busy, 0);
    check("fw_idle_wr", rf_reg_write, 0);
    check("fw_hold_wreg", rf_write_reg, 5);

    // Byte write from MEM through RMW.
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h000000AB; mem_be = 4'b0001;
    rf_read_data = 32'h11223344;
    #1;
    check("by_mem_ready", mem_ready, 1);
    check("by_alu_ready", alu_ready, 0);
    step();
    mem_valid = 1'b0;
    #1;
    check("by_rreg", rf_read_reg, 9);
    check("by_read_wr", rf_reg_write, 0);
    check("by_busy", busy, 1);
    step();
    check("by_wr", rf_reg_write, 1);
    check("by_wreg", rf_write_reg, 9);
    check("by_wdata", rf_write_data, 32'h112233AB);
    check("by_rreg_off", rf_read_reg, 0);
    step();

    // Mixed lanes: lanes 3 and 1 new, lanes 2 and 0 old.
    alu_valid = 1'b1; alu_reg = 5'd17; alu_data = 32'hCAFE1234; alu_be = 4'b1010;
    #1;
    check("mx_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    #1;
    check("mx_rreg", rf_read_reg, 17);
    step();
    check("mx_wr", rf_reg_write, 1);
    check("mx_wdata", rf_write_data, 32'hCA221244);
    step();

    // Discards: register 0, then empty byte enables.
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h55555555; alu_be = 4'hF;
    #1;
    check("dz_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    #1;
    check("dz_busy", busy, 0);
    check("dz_wr", rf_reg_write, 0);
    check("dz_wreg_hold", rf_write_reg, 17);
    alu_valid = 1'b1; alu_reg = 5'd4; alu_be = 4'b0000;
    #1;
    check("db_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    #1;
    check("db_busy", busy, 0);
    check("db_wr", rf_reg_write, 0);

    // Back-to-back full words with valid held.
    alu_valid = 1'b1; alu_reg = 5'd12; alu_be = 4'hF;
    for (int k = 0; k < 3; k++) begin
      alu_data = 32'hA0000000 | k;
      #1;
      check("b2b_ready", alu_ready, 1);
      step();
      check("b2b_no_ready", alu_ready, 0);
      check("b2b_wr", rf_reg_write, 1);
      check("b2b_wdata", rf_write_data, 32'hA0000000 | k);
      step();
    end
    alu_valid = 1'b0;

    // Contention from a fresh reset so the pointer starts favouring MEM.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h77777777; mem_be = 4'hF;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33333333; alu_be = 4'hF;
    for (int k = 0; k < 3; k++) begin
`ifdef REGW_ROUND_ROBIN_EN
      exp_mem = (k != 1);
`else
      exp_mem = 1'b1;
`endif
      #1;
      check("ct_mem_ready", mem_ready, exp_mem);
      check("ct_alu_ready", alu_ready, !exp_mem);
      step();
      check("ct_wreg", rf_write_reg, exp_mem ? 32'd7 : 32'd3);
      step();
    end
    mem_valid = 1'b0;
    #1;
    check("ct_alu_last", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    #1;
    check("ct_alu_wreg", rf_write_reg, 3);
    step();

    // Asynchronous reset in the middle of a read-modify-write.
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h000000AB; mem_be = 4'b0001;
    step();
    mem_valid = 1'b0;
    #1;
    check("rr_rreg", rf_read_reg, 9);
    check("rr_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rr_busy_clr", busy, 0);
    check("rr_wr_clr", rf_reg_write, 0);
    check("rr_rreg_clr", rf_read_reg, 0);
    check("rr_wreg_clr", rf_write_reg, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr_no_write", rf_reg_write, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
